// File: rtl/seq_mult_32b.sv
// ============================================================================
// Module      : seq_mult_32b
// Description : 32x32 unsigned shift-and-add multiplier producing a 64-bit
//               product over 32 iterations through one ripple-carry adder.
//               Optional macro SEQ_MULT_EARLY_ZERO_EN skips the iterations
//               when either operand is zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_32B (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_cin,
    output logic [31:0] o_sum,
    output logic        o_cout,
    output logic        o_overflow
);

    logic [32:0] w_c;

    assign w_c[0] = i_cin;

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_fa
            assign o_sum[gi]  = i_a[gi] ^ i_b[gi] ^ w_c[gi];
            assign w_c[gi+1]  = (i_a[gi] & i_b[gi]) | (w_c[gi] & (i_a[gi] ^ i_b[gi]));
        end
    endgenerate

    assign o_cout     = w_c[32];
    assign o_overflow = w_c[32] ^ w_c[31];

endmodule

module seq_mult_32b (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [63:0] product,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [5:0] C_LAST_ITER = 6'd31;

    logic [1:0]  r_state;
    logic [1:0]  w_next;
    logic [31:0] r_mcand;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [5:0]  r_cnt;
    logic [63:0] r_product;
    logic [31:0] w_sum;
    logic        w_cout;
    logic        w_ovf_unused;
    logic [63:0] w_step;
    logic        w_zero;

    adder_32B u_adder (
        .i_a        (r_hi),
        .i_b        (r_mcand),
        .i_cin      (1'b0),
        .o_sum      (w_sum),
        .o_cout     (w_cout),
        .o_overflow (w_ovf_unused)
    );

    // Add-then-shift: the adder carry becomes the new MSB of hi.
    assign w_step = r_lo[0] ? {w_cout, w_sum, r_lo[31:1]}
                            : {1'b0, r_hi, r_lo[31:1]};

`ifdef SEQ_MULT_EARLY_ZERO_EN
    assign w_zero = (A == 32'h0) || (B == 32'h0);
`else
    assign w_zero = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = w_zero ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (r_cnt == C_LAST_ITER) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand   <= 32'h0;
            r_hi      <= 32'h0;
            r_lo      <= 32'h0;
            r_cnt     <= 6'd0;
            r_product <= 64'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mcand   <= A;
                        r_hi      <= 32'h0;
                        r_lo      <= B;
                        r_cnt     <= 6'd0;
                        r_product <= 64'h0;
                    end
                end
                S_RUN: begin
                    {r_hi, r_lo} <= w_step;
                    r_cnt        <= r_cnt + 6'd1;
                    if (r_cnt == C_LAST_ITER) begin
                        r_product <= w_step;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign product = r_product;

endmodule

`default_nettype wire
